// File: rtl/seg_line_scheduler_pkg.sv
// seg_line_scheduler_pkg: shared sprite/snake constants and scheduler FSM encoding
package seg_line_scheduler_pkg;
  localparam int SNK_BLK_SIZE = 32;
  localparam int SNK_MAX_SEGMENTS = 23;
  localparam int SNK_COORD_W = 11;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_READY} state_t;
endpackage

// File: rtl/seg_slot_match.sv
// seg_slot_match: x-range compare of every slot against the pixel, lowest matching slot wins
module seg_slot_match
  import seg_line_scheduler_pkg::*;
#(
  parameter int SLOTS = 8,
  parameter int BLK_SIZE = SNK_BLK_SIZE,
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [SLOTS-1:0]       i_valid,
  input  logic [SNK_COORD_W-1:0] i_x [SLOTS],
  input  logic [SNK_COORD_W-1:0] i_curr_x,
  output logic                   o_match,
  output logic [SW-1:0]          o_sel
);
  localparam logic [SNK_COORD_W:0] W_BLK = (SNK_COORD_W+1)'(BLK_SIZE);
  logic [SLOTS-1:0] w_hit;
  logic [SNK_COORD_W:0] w_px;
  assign w_px = {1'b0, i_curr_x};
  // compare at one extra bit so a sprite near the right edge never wraps
  for (genvar g = 0; g < SLOTS; g++) begin : g_cmp
    logic [SNK_COORD_W:0] w_lo;
    assign w_lo = {1'b0, i_x[g]};
    assign w_hit[g] = i_valid[g] && (w_px >= w_lo) && (w_px < w_lo + W_BLK);
  end
  always_comb begin
    o_match = 1'b0;
    o_sel = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (w_hit[s]) begin
        o_match = 1'b1;
        o_sel = SW'(s);
      end
    end
  end
endmodule

// File: rtl/seg_line_scheduler.sv
// seg_line_scheduler: builds a per-line table of intersecting snake segments and looks up pixels in it
module seg_line_scheduler
  import seg_line_scheduler_pkg::*;
#(
  parameter int BLK_SIZE = SNK_BLK_SIZE,
  parameter int MAX_SEGMENTS = SNK_MAX_SEGMENTS,
  parameter int SLOTS = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  line_start,
  input  logic [SNK_COORD_W-1:0]                next_y,
  input  logic [MAX_SEGMENTS*SNK_COORD_W-1:0]   snakepos_x,
  input  logic [MAX_SEGMENTS*SNK_COORD_W-1:0]   snakepos_y,
  input  logic [5:0]                            length,
  input  logic                                  pix_valid,
  input  logic [SNK_COORD_W-1:0]                curr_x,
  output logic                                  hit,
  output logic [4:0]                            seg_idx,
  output logic                                  is_head,
  output logic [9:0]                            rom_addr,
  output logic                                  busy,
  output logic                                  overflow
);
  localparam int CW = SNK_COORD_W;
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FW = $clog2(SLOTS + 1);
  localparam int BW = $clog2(BLK_SIZE);
  localparam logic [CW:0] W_BLK = (CW+1)'(BLK_SIZE);

  state_t r_state, w_next;
  logic [CW-1:0] r_y;
  logic [4:0] r_cnt, r_n, w_n;
  logic [FW-1:0] r_fill;
  logic [SLOTS-1:0] r_sv;
  logic [CW-1:0] r_sx [SLOTS];
  logic [4:0] r_sidx [SLOTS];
  logic [BW-1:0] r_srow [SLOTS];
  logic [CW-1:0] w_xa [MAX_SEGMENTS];
  logic [CW-1:0] w_ya [MAX_SEGMENTS];
  logic [CW-1:0] w_xi, w_yi;
  logic [BW-1:0] w_row, w_col;
  logic [SW-1:0] w_wr, w_sel;
  logic w_done, w_isect, w_full, w_store, w_match, w_look;

  for (genvar g = 0; g < MAX_SEGMENTS; g++) begin : g_unpack
    assign w_xa[g] = snakepos_x[g*CW +: CW];
    assign w_ya[g] = snakepos_y[g*CW +: CW];
  end

  assign w_n = (length > 6'(MAX_SEGMENTS)) ? 5'(MAX_SEGMENTS) : length[4:0];
  assign w_xi = w_xa[r_cnt];
  assign w_yi = w_ya[r_cnt];
  assign w_done = (r_n == 5'd0) || (r_cnt == r_n - 5'd1);
  // y window compared at 12 bits so a segment near the bottom never wraps to the top
  assign w_isect = (r_cnt < r_n) && ({1'b0, w_yi} <= {1'b0, r_y}) && ({1'b0, r_y} < {1'b0, w_yi} + W_BLK);
  assign w_row = BW'(r_y - w_yi);
  assign w_full = (r_fill == FW'(SLOTS));
  assign w_wr = r_fill[SW-1:0];
  assign w_store = (r_state == ST_SCAN) && !line_start && w_isect && !w_full;
  assign busy = (r_state == ST_SCAN);

  always_comb begin
    w_next = line_start ? ST_SCAN : (r_state == ST_SCAN && w_done) ? ST_READY : r_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  seg_slot_match #(.SLOTS(SLOTS), .BLK_SIZE(BLK_SIZE)) u_match (
    .i_valid  (r_sv),
    .i_x      (r_sx),
    .i_curr_x (curr_x),
    .o_match  (w_match),
    .o_sel    (w_sel)
  );

  assign w_look = (r_state == ST_READY) && pix_valid && w_match;
  assign w_col = BW'(curr_x - r_sx[w_sel]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y <= '0;
      r_n <= '0;
      r_cnt <= '0;
      r_fill <= '0;
      r_sv <= '0;
      overflow <= 1'b0;
      hit <= 1'b0;
      seg_idx <= '0;
      is_head <= 1'b0;
      rom_addr <= '0;
    end else begin
      if (line_start) begin
        r_y <= next_y;
        r_n <= w_n;
        r_cnt <= '0;
        r_fill <= '0;
        r_sv <= '0;
        overflow <= 1'b0;
      end else if (r_state == ST_SCAN) begin
        if (!w_done) r_cnt <= r_cnt + 5'd1;
        if (w_isect && w_full) overflow <= 1'b1;
        if (w_store) begin
          r_sv[w_wr] <= 1'b1;
          r_fill <= r_fill + FW'(1);
        end
      end
      hit <= w_look;
      seg_idx <= w_look ? r_sidx[w_sel] : 5'd0;
      is_head <= w_look && (r_sidx[w_sel] == 5'd0);
      rom_addr <= w_look ? 10'({r_srow[w_sel], w_col}) : 10'd0;
    end
  end

  // slot payload is qualified by r_sv, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_sidx[w_wr] <= r_cnt;
      r_sx[w_wr] <= w_xi;
      r_srow[w_wr] <= w_row;
    end
  end
endmodule

// File: tb/tb_seg_line_scheduler.sv
// tb_seg_line_scheduler: directed checks of table build, pixel lookup, overflow, wrap and reset
module tb_seg_line_scheduler;
  logic clk = 1'b0, rst = 1'b0, line_start = 1'b0, pix_valid = 1'b0;
  logic [10:0] next_y = '0, curr_x = '0;
  logic [252:0] sx = '0, sy = '0;
  logic [5:0] length = '0;
  logic hit, is_head, busy, overflow;
  logic [4:0] seg_idx;
  logic [9:0] rom_addr;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  seg_line_scheduler dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_y(next_y),
    .snakepos_x(sx), .snakepos_y(sy), .length(length), .pix_valid(pix_valid),
    .curr_x(curr_x), .hit(hit), .seg_idx(seg_idx), .is_head(is_head),
    .rom_addr(rom_addr), .busy(busy), .overflow(overflow)
  );

  function automatic logic [16:0] px(input int h, input int idx, input int hd, input int ra);
    return {1'(h), 5'(idx), 1'(hd), 10'(ra)};
  endfunction

  task automatic set_seg(input int i, input int x, input int y);
    sx[11*i +: 11] = 11'(x);
    sy[11*i +: 11] = 11'(y);
  endtask

  task automatic clear_segs;
    for (int i = 0; i < 23; i++) set_seg(i, 0, 1500);
  endtask

  task automatic run_scan(input int y, output int cyc);
    @(negedge clk) line_start = 1'b1; next_y = 11'(y);
    @(negedge clk) line_start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic look(input int x, output logic [16:0] r);
    @(negedge clk) pix_valid = 1'b1; curr_x = 11'(x);
    @(negedge clk) r = {hit, seg_idx, is_head, rom_addr};
    pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_vec++; if ({hit, seg_idx, is_head, rom_addr} !== 17'd0) begin n_err++; $display("FAIL reset_lookup got %h exp 0", {hit, seg_idx, is_head, rom_addr}); end
    n_vec++; if ({busy, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_busy_ovf got %b exp 00", {busy, overflow}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic;
    int c; logic [16:0] r;
    clear_segs(); length = 6'd3;
    set_seg(0, 300, 100); set_seg(1, 310, 120); set_seg(2, 500, 200);
    run_scan(110, c);
    n_vec++; if (c != 3) begin n_err++; $display("FAIL basic_busy got %0d exp 3", c); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b exp 0", overflow); end
    look(305, r);
    n_vec++; if (r !== px(1, 0, 1, 325)) begin n_err++; $display("FAIL basic_305 got %h exp %h", r, px(1, 0, 1, 325)); end
    look(340, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL basic_340 got %h exp 0", r); end
    @(negedge clk);
    n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL pix_invalid got %b exp 0", hit); end
  endtask

  task automatic test_priority;
    int c; logic [16:0] r;
    run_scan(120, c);
    n_vec++; if (c != 3) begin n_err++; $display("FAIL prio_busy got %0d exp 3", c); end
    look(340, r);
    n_vec++; if (r !== px(1, 1, 0, 30)) begin n_err++; $display("FAIL prio_340 got %h exp %h", r, px(1, 1, 0, 30)); end
    look(342, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL prio_342 got %h exp 0", r); end
    look(315, r);
    n_vec++; if (r !== px(1, 0, 1, 655)) begin n_err++; $display("FAIL prio_315 got %h exp %h", r, px(1, 0, 1, 655)); end
    look(305, r);
    n_vec++; if (r !== px(1, 0, 1, 645)) begin n_err++; $display("FAIL prio_305 got %h exp %h", r, px(1, 0, 1, 645)); end
  endtask

  task automatic test_overflow;
    int c; logic [16:0] r;
    clear_segs(); length = 6'd12;
    for (int i = 0; i < 12; i++) set_seg(i, 64 * i, 50);
    run_scan(60, c);
    n_vec++; if (c != 12) begin n_err++; $display("FAIL ovf_busy got %0d exp 12", c); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    look(449, r);
    n_vec++; if (r !== px(1, 7, 0, 321)) begin n_err++; $display("FAIL ovf_seg7 got %h exp %h", r, px(1, 7, 0, 321)); end
    look(513, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL ovf_seg8 got %h exp 0", r); end
    look(705, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL ovf_seg11 got %h exp 0", r); end
    run_scan(0, c);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    look(449, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL ovf_y0 got %h exp 0", r); end
  endtask

  task automatic test_wrap;
    int c; logic [16:0] r;
    clear_segs(); length = 6'd1;
    set_seg(0, 0, 2040);
    run_scan(2045, c);
    n_vec++; if (c != 1) begin n_err++; $display("FAIL wrap_busy got %0d exp 1", c); end
    look(3, r);
    n_vec++; if (r !== px(1, 0, 1, 163)) begin n_err++; $display("FAIL wrap_2045 got %h exp %h", r, px(1, 0, 1, 163)); end
    run_scan(5, c);
    look(3, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL wrap_5 got %h exp 0", r); end
  endtask

  task automatic test_max_len;
    int c;
    clear_segs(); length = 6'd40;
    run_scan(10, c);
    n_vec++; if (c != 23) begin n_err++; $display("FAIL maxlen_busy got %0d exp 23", c); end
  endtask

  task automatic test_len_zero;
    int c; logic [16:0] r;
    clear_segs(); set_seg(0, 300, 100); length = 6'd0;
    run_scan(110, c);
    n_vec++; if (c != 1) begin n_err++; $display("FAIL len0_busy got %0d exp 1", c); end
    look(305, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL len0_305 got %h exp 0", r); end
    look(0, r);
    n_vec++; if (r !== px(0, 0, 0, 0)) begin n_err++; $display("FAIL len0_0 got %h exp 0", r); end
  endtask

  task automatic test_async_reset;
    int c; logic [16:0] r;
    clear_segs(); length = 6'd10;
    set_seg(0, 300, 100); set_seg(1, 310, 120); set_seg(2, 500, 200);
    run_scan(110, c);
    @(negedge clk) pix_valid = 1'b1; curr_x = 11'd305;
    @(negedge clk);
    n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL pre_reset_hit got %b exp 1", hit); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if ({hit, seg_idx, is_head, rom_addr} !== 17'd0) begin n_err++; $display("FAIL async_clear got %h exp 0", {hit, seg_idx, is_head, rom_addr}); end
    @(negedge clk) rst = 1'b1; pix_valid = 1'b0;
    @(negedge clk) line_start = 1'b1; next_y = 11'd110;
    @(negedge clk) line_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midscan_busy got %b exp 1", busy); end
    #2 rst = 1'b0;
    #1;
    n_vec++; if ({busy, overflow, hit} !== 3'b000) begin n_err++; $display("FAIL midscan_reset got %b exp 000", {busy, overflow, hit}); end
    @(negedge clk) rst = 1'b1; pix_valid = 1'b1; curr_x = 11'd305;
    repeat (15) @(negedge clk);
    n_vec++; if ({busy, hit} !== 2'b00) begin n_err++; $display("FAIL post_reset_idle got %b exp 00", {busy, hit}); end
    pix_valid = 1'b0;
    run_scan(110, c);
    n_vec++; if (c != 10) begin n_err++; $display("FAIL rescan_busy got %0d exp 10", c); end
    look(305, r);
    n_vec++; if (r !== px(1, 0, 1, 325)) begin n_err++; $display("FAIL rescan_305 got %h exp %h", r, px(1, 0, 1, 325)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_overflow();
    test_wrap();
    test_max_len();
    test_len_zero();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
